// File: rtl/mem_rmw_ctrl_if.sv
// Request/response/RAM bundle for mem_rmw_ctrl.
// Latency: none; this is a plain signal bundle.
// Backpressure: req_valid/req_ready and rsp_valid/rsp_ready carry the flow control.
// Ports: req_* (MEM-stage request), rsp_* (response), ram_* (word-only single-port RAM).
// slave = controller side, master = requester/RAM side.
interface mem_rmw_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_sel;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_re;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  req_valid, req_write, req_sel, req_addr, req_wdata, rsp_ready, ram_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_re, ram_we, ram_wdata
    );

    modport master (
        output req_valid, req_write, req_sel, req_addr, req_wdata, rsp_ready, ram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_re, ram_we, ram_wdata
    );
endinterface

// File: rtl/mem_rmw_ctrl.sv
// Sequences word/half/byte loads and stores onto a word-only sync RAM; sub-word stores do read-modify-write.
// Latency (accept edge counted as 1 to rsp_valid): error 1, word store 2, load 3, sub-word store 4.
// Backpressure: one request in flight; req_ready only in IDLE; response held until rsp_ready.
// Ports: clk, reset (async active-low), bus (mem_rmw_ctrl_if.slave: req_*, rsp_*, ram_*).
module mem_rmw_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic          clk,
    input  logic          reset,
    mem_rmw_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

    localparam logic [1:0] SEL_WORD = 2'b00;
    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_BYTE = 2'b10;

    state_t            state;
    logic              lat_write;
    logic [1:0]        lat_sel;
    logic [1:0]        lat_lo;
    logic [15:0]       lat_wdata;
    logic              req_err;
    logic [ADDR_W-1:0] req_waddr;
    logic              unused_addr_hi;

    // Alignment / reserved-size check on the live request, used only at accept.
    always_comb begin
        req_err = 1'b0;
        case (bus.req_sel)
            SEL_WORD: req_err = (bus.req_addr[1:0] != 2'b00);
            SEL_HALF: req_err = bus.req_addr[0];
            SEL_BYTE: req_err = 1'b0;
            default:  req_err = 1'b1;
        endcase
    end

    // Upper address bits are dropped so accesses wrap onto the RAM depth.
    assign req_waddr      = bus.req_addr[ADDR_W+1:2];
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    // Replace the addressed lanes of the RAM word with the store data.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] sel,
                                          input logic [1:0] lo, input logic [15:0] wd);
        logic [31:0] w;
        w = old;
        if (sel == SEL_HALF) begin
            if (lo[1]) w[31:16] = wd;
            else       w[15:0]  = wd;
        end else begin
            case (lo)
                2'd0:    w[7:0]   = wd[7:0];
                2'd1:    w[15:8]  = wd[7:0];
                2'd2:    w[23:16] = wd[7:0];
                default: w[31:24] = wd[7:0];
            endcase
        end
        return w;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            lat_write     <= 1'b0;
            lat_sel       <= SEL_WORD;
            lat_lo        <= 2'b00;
            lat_wdata     <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_re    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_wdata <= '0;
        end else begin
            // Strobes are single-cycle pulses; only the state that raises them keeps them high.
            bus.ram_re <= 1'b0;
            bus.ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        lat_write     <= bus.req_write;
                        lat_sel       <= bus.req_sel;
                        lat_lo        <= bus.req_addr[1:0];
                        lat_wdata     <= bus.req_wdata[15:0];
                        bus.req_ready <= 1'b0;
                        if (req_err) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                            state         <= RESP;
                        end else begin
                            bus.ram_addr <= req_waddr;
                            if (bus.req_write && bus.req_sel == SEL_WORD) begin
                                // Full-word store needs no read of the old word.
                                bus.ram_we    <= 1'b1;
                                bus.ram_wdata <= bus.req_wdata;
                                state         <= WRITE;
                            end else begin
                                bus.ram_re <= 1'b1;
                                state      <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // RAM data is valid now: it becomes either the merged store word or the load result.
                    if (lat_write) begin
                        bus.ram_wdata <= merge(bus.ram_rdata, lat_sel, lat_lo, lat_wdata);
                        bus.ram_we    <= 1'b1;
                        state         <= WRITE;
                    end else begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= bus.ram_rdata;
                        bus.rsp_err   <= 1'b0;
                        state         <= RESP;
                    end
                end
                WRITE: begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_rdata <= '0;
                    bus.rsp_err   <= 1'b0;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Randomized scoreboard bench for mem_rmw_ctrl with a behavioural memory model.
// Latency is measured from the accept edge (counted as 1) to the edge raising rsp_valid.
// rsp_ready is randomized, forced low, or forced high to exercise backpressure.
module tb_mem_rmw_ctrl;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct {
        logic [31:0]       rdata;
        logic              err;
        int                lat;
        int                n_re;
        int                n_we;
        logic [ADDR_W-1:0] waddr;
        logic [31:0]       wdata;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_rmw_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
    mem_rmw_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [31:0] ram     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rdy_mode = 0;

    // Word-only synchronous RAM the controller drives.
    always @(posedge clk) begin
        cyc++;
        if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
        if (bus.ram_re) bus.ram_rdata <= ram[bus.ram_addr];
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
            1:       bus.rsp_ready = 1'b0;
            default: bus.rsp_ready = 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: size/alignment rules and byte-lane replacement on a word array.
    task automatic model(input logic wr, input logic [1:0] sel, input logic [31:0] addr,
                         input logic [31:0] wd, output exp_t e);
        int          widx, size, base;
        logic [31:0] nw;
        widx = int'((addr >> 2) % DEPTH);
        size = (sel == 2'd0) ? 4 : (sel == 2'd1) ? 2 : 1;
        e.rdata = '0; e.err = 1'b0; e.lat = 0; e.n_re = 0; e.n_we = 0; e.waddr = '0; e.wdata = '0;
        if (sel == 2'd3 || (addr % size) != 0) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (!wr) begin
            e.rdata = ref_mem[widx];
            e.lat   = 3;
            e.n_re  = 1;
        end else begin
            base = int'(addr % 4);
            nw   = ref_mem[widx];
            for (int b = 0; b < size; b++) nw[8*(base+b) +: 8] = wd[8*b +: 8];
            ref_mem[widx] = nw;
            e.n_we  = 1;
            e.waddr = ADDR_W'(widx);
            e.wdata = nw;
            e.lat   = (size == 4) ? 2 : 4;
            e.n_re  = (size == 4) ? 0 : 1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input logic wr, input logic [1:0] sel, input logic [31:0] addr,
                         input logic [31:0] wd, input bit track);
        int   waited;
        exp_t e;
        bus.req_write = wr; bus.req_sel = sel; bus.req_addr = addr; bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            if (++waited > 60) begin
                n_chk++; n_fail++;
                $display("FAIL accept_timeout: req_ready low for %0d cycles", waited);
                break;
            end
        end
        if (track && bus.req_ready) begin
            model(wr, sel, addr, wd, e);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        // Inputs are don't-care after accept; scramble them.
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom); bus.req_sel = 2'($urandom);
        bus.req_addr  = $urandom;     bus.req_wdata = $urandom;
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (sb.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding", sb.size());
        end
    endtask

    // Monitor: strobe bookkeeping, stability, latency and scoreboard pops.
    int          acc_cyc = 0, rise_cyc = 0, re_cnt = 0, we_cnt = 0;
    logic [ADDR_W-1:0] last_waddr;
    logic [31:0] last_wdata, prev_rdata;
    logic        prev_valid = 1'b0, prev_hs = 1'b0, prev_err;
    always @(negedge clk) begin
        exp_t e;
        logic hs;
        if (!reset) begin
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
            chk("rst_req_ready", 32'(bus.req_ready), 1);
            chk("rst_ram_strobes", {30'd0, bus.ram_re, bus.ram_we}, 0);
            chk("rst_outputs", bus.rsp_rdata | bus.ram_wdata | 32'(bus.ram_addr) | 32'(bus.rsp_err), 0);
            sb.delete();
            prev_valid = 1'b0; prev_hs = 1'b0;
        end else begin
            if (bus.ram_re || bus.ram_we) chk("re_we_exclusive", 32'(bus.ram_re & bus.ram_we), 0);
            if (bus.ram_re) re_cnt++;
            if (bus.ram_we) begin we_cnt++; last_waddr = bus.ram_addr; last_wdata = bus.ram_wdata; end
            if (bus.req_valid && bus.req_ready) begin acc_cyc = cyc; re_cnt = 0; we_cnt = 0; end
            if (prev_hs && bus.req_valid) chk("b2b_req_ready", 32'(bus.req_ready), 1);
            if (bus.rsp_valid) begin
                chk("req_ready_in_resp", 32'(bus.req_ready), 0);
                if (!prev_valid || prev_hs) rise_cyc = cyc;
                else begin
                    chk("rsp_rdata_stable", bus.rsp_rdata, prev_rdata);
                    chk("rsp_err_stable", 32'(bus.rsp_err), 32'(prev_err));
                end
            end
            hs = bus.rsp_valid && bus.rsp_ready;
            if (hs) begin
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_rsp: response with empty scoreboard, rdata 0x%08h", bus.rsp_rdata);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    chk("latency", rise_cyc - acc_cyc, e.lat);
                    chk("ram_re_count", re_cnt, e.n_re);
                    chk("ram_we_count", we_cnt, e.n_we);
                    if (e.n_we != 0) begin
                        chk("ram_waddr", 32'(last_waddr), 32'(e.waddr));
                        chk("ram_wdata", last_wdata, e.wdata);
                    end
                end
            end
            prev_valid = bus.rsp_valid; prev_hs = hs;
            prev_rdata = bus.rsp_rdata; prev_err = bus.rsp_err;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int          mism, waited;
        logic [31:0] a;
        int          r;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_sel = 2'b00;
        bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin ram[i] = $urandom; ref_mem[i] = ram[i]; end
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // T1 word store
        issue(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 1'b1); drain();
        chk("T1_ram4", ram[4], 32'hDEADBEEF);
        // T2 byte store merge
        issue(1'b1, 2'b00, 32'h10, 32'h11223344, 1'b1);
        issue(1'b1, 2'b10, 32'h12, 32'h000000AB, 1'b1); drain();
        chk("T2_ram4", ram[4], 32'h11AB3344);
        // T3 half store merge, then load
        issue(1'b1, 2'b00, 32'h10, 32'h11223344, 1'b1);
        issue(1'b1, 2'b01, 32'h12, 32'h0000CAFE, 1'b1);
        issue(1'b0, 2'b00, 32'h10, 32'h0, 1'b1); drain();
        chk("T3_ram4", ram[4], 32'hCAFE3344);
        // T4 misaligned half store and word load, plus reserved size
        issue(1'b1, 2'b01, 32'h13, 32'h1234, 1'b1);
        issue(1'b0, 2'b00, 32'h02, 32'h0, 1'b1);
        issue(1'b0, 2'b11, 32'h10, 32'h0, 1'b1); drain();
        chk("T4_ram4", ram[4], 32'hCAFE3344);

        // Random traffic with address wrap and random idle gaps.
        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 9);
            a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            issue(1'($urandom), (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11,
                  a, $urandom, 1'b1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        drain();

        // T5 response held 5 cycles, then back-to-back request
        rdy_mode = 1;
        @(posedge clk); #1;
        issue(1'b0, 2'b00, 32'h10, 32'h0, 1'b1);
        waited = 0;
        while (!bus.rsp_valid && waited < 20) begin @(negedge clk); waited++; end
        chk("T5_rsp_valid_seen", 32'(bus.rsp_valid), 1);
        repeat (5) @(posedge clk);
        rdy_mode = 2;
        #1;
        issue(1'b1, 2'b00, 32'h20, 32'h5A5A_A5A5, 1'b1);
        drain();
        rdy_mode = 0;

        // T6 reset during WAIT of a byte store
        issue(1'b1, 2'b10, 32'h12, 32'h000000EE, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("T6_ram_we_now", 32'(bus.ram_we), 0);
        chk("T6_rsp_valid_now", 32'(bus.rsp_valid), 0);
        chk("T6_req_ready_now", 32'(bus.req_ready), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("T6_ram4_unchanged", ram[4], ref_mem[4]);

        issue(1'b0, 2'b00, 32'h10, 32'h0, 1'b1);
        drain();
        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) mism++;
        chk("final_mem_mismatches", mism, 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
